// File: rtl/router_pkt_tx_pkg.sv
`default_nettype none
// ============================================================================
// router_pkg : shared types and constants for the router packet transmitter
// Revision   : 1.0
// ============================================================================
package router_pkg;

    typedef enum logic [2:0] {
        TX_IDLE    = 3'd0,
        TX_FILL    = 3'd1,
        TX_HEADER  = 3'd2,
        TX_PAYLOAD = 3'd3,
        TX_PARITY  = 3'd4,
        TX_GAP     = 3'd5
    } tx_state_t;

    localparam int MAX_LEN = 63;

    localparam int c_hdr_addr_lsb = 0;
    localparam int c_hdr_addr_msb = 1;
    localparam int c_hdr_len_lsb  = 2;
    localparam int c_hdr_len_msb  = 7;

    localparam logic [1:0] c_dest_invalid = 2'b11;

    function automatic logic [7:0] make_header(input logic [5:0] len, input logic [1:0] dest);
        logic [7:0] hdr;
        hdr = '0;
        hdr[c_hdr_len_msb:c_hdr_len_lsb]   = len;
        hdr[c_hdr_addr_msb:c_hdr_addr_lsb] = dest;
        return hdr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_pkt_tx_if.sv
`default_nettype none
// ============================================================================
// router_pkt_tx_if : command, payload and router-side wire bundle of the
//                    packet transmitter (master = transmitter side)
// Revision         : 1.0
// ============================================================================
interface router_pkt_tx_if;
    import router_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_dest;
    logic [5:0] cmd_len;
    logic       cmd_bad_parity;
    logic       cmd_err;
    logic       pl_valid;
    logic       pl_ready;
    logic [7:0] pl_data;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       busy;
    logic       done;

    modport master (
        input  cmd_valid, cmd_dest, cmd_len, cmd_bad_parity, pl_valid, pl_data, busy,
        output cmd_ready, cmd_err, pl_ready, data_out, pkt_valid, done
    );

    modport slave (
        output cmd_valid, cmd_dest, cmd_len, cmd_bad_parity, pl_valid, pl_data, busy,
        input  cmd_ready, cmd_err, pl_ready, data_out, pkt_valid, done
    );
endinterface
`default_nettype wire

// File: rtl/router_tx_buf.sv
`default_nettype none
// ============================================================================
// router_tx_buf : simple dual-port payload RAM, one write port and one
//                 registered read port; storage is not reset
// Revision      : 1.0
// ============================================================================
module router_tx_buf
    import router_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 8
) (
    input  wire logic          clock,
    input  wire logic          wr_en,
    input  wire logic [AW-1:0] wr_addr,
    input  wire logic [DW-1:0] wr_data,
    input  wire logic [AW-1:0] rd_addr,
    output logic      [DW-1:0] rd_data
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        rd_data <= r_mem[rd_addr];
    end

endmodule
`default_nettype wire

// File: rtl/router_pkt_tx.sv
`default_nettype none
// ============================================================================
// router_pkt_tx : buffers a full payload, then sends header / payload /
//                 parity to the router honouring busy, followed by a gap
// Revision      : 1.0
// ============================================================================
module router_pkt_tx #(
    parameter int MAX_LEN    = router_pkg::MAX_LEN,
    parameter int GAP_CYCLES = 2
) (
    input  wire logic       clock,
    input  wire logic       resetn,
    router_pkt_tx_if.master tx
);
    import router_pkg::*;

    localparam int         c_depth    = MAX_LEN + 1;
    localparam logic [3:0] c_gap_last = 4'(GAP_CYCLES - 1);

    tx_state_t  r_state;
    tx_state_t  w_state_nxt;
    logic       r_started;
    logic       r_bad_parity;
    logic       r_cmd_err;
    logic [5:0] r_len;
    logic [5:0] r_wcnt;
    logic [5:0] r_rcnt;
    logic [3:0] r_gcnt;
    logic [7:0] r_header;
    logic [7:0] r_parity;

    logic       w_cmd_ready;
    logic       w_cmd_hs;
    logic       w_cmd_reject;
    logic [7:0] w_cmd_header;
    logic       w_wr_en;
    logic       w_wr_last;
    logic       w_xfer;
    logic       w_rd_last;
    logic       w_gap_last;
    logic [5:0] w_rd_addr;
    logic [7:0] w_rd_data;
    logic [7:0] w_data_out;
    logic       w_pkt_valid;

    // cmd_ready is held low for the first cycle after reset release
    assign w_cmd_ready  = (r_state == TX_IDLE) && r_started;
    assign w_cmd_hs     = tx.cmd_valid && w_cmd_ready;
    assign w_cmd_reject = (tx.cmd_dest == c_dest_invalid) || (tx.cmd_len == 6'd0);
    assign w_cmd_header = make_header(tx.cmd_len, tx.cmd_dest);
    assign w_wr_en      = tx.pl_valid && (r_state == TX_FILL);
    assign w_wr_last    = (r_wcnt == r_len - 6'd1);
    assign w_xfer       = !tx.busy;
    assign w_rd_last    = (r_rcnt == r_len - 6'd1);
    assign w_gap_last   = (r_gcnt == c_gap_last);

    // Read address runs one ahead so the RAM output register already holds
    // buf[rcnt] whenever PAYLOAD shows byte rcnt.
    always_comb begin
        w_rd_addr = r_rcnt;
        if ((r_state == TX_PAYLOAD) && w_xfer) begin
            w_rd_addr = r_rcnt + 6'd1;
        end
    end

    router_tx_buf #(
        .DEPTH (c_depth),
        .AW    (6),
        .DW    (8)
    ) u_buf (
        .clock   (clock),
        .wr_en   (w_wr_en),
        .wr_addr (r_wcnt),
        .wr_data (tx.pl_data),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Wire outputs are decoded only from flops (state, header, parity, RAM
    // output register), so busy never reaches data_out/pkt_valid.
    always_comb begin
        w_state_nxt = r_state;
        w_data_out  = 8'h00;
        w_pkt_valid = 1'b0;
        unique case (r_state)
            TX_IDLE: begin
                if (w_cmd_hs && !w_cmd_reject) begin
                    w_state_nxt = TX_FILL;
                end
            end
            TX_FILL: begin
                if (w_wr_en && w_wr_last) begin
                    w_state_nxt = TX_HEADER;
                end
            end
            TX_HEADER: begin
                w_data_out  = r_header;
                w_pkt_valid = 1'b1;
                if (w_xfer) begin
                    w_state_nxt = TX_PAYLOAD;
                end
            end
            TX_PAYLOAD: begin
                w_data_out  = w_rd_data;
                w_pkt_valid = 1'b1;
                if (w_xfer && w_rd_last) begin
                    w_state_nxt = TX_PARITY;
                end
            end
            TX_PARITY: begin
                w_data_out = r_parity ^ {8{r_bad_parity}};
                if (w_xfer) begin
                    w_state_nxt = TX_GAP;
                end
            end
            TX_GAP: begin
                if (w_gap_last) begin
                    w_state_nxt = TX_IDLE;
                end
            end
            default: begin
                w_state_nxt = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_started    <= 1'b0;
            r_bad_parity <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_len        <= '0;
            r_wcnt       <= '0;
            r_rcnt       <= '0;
            r_gcnt       <= '0;
            r_header     <= '0;
            r_parity     <= '0;
        end else begin
            r_started <= 1'b1;
            r_cmd_err <= w_cmd_hs && w_cmd_reject;
            case (r_state)
                TX_IDLE: begin
                    if (w_cmd_hs && !w_cmd_reject) begin
                        r_len        <= tx.cmd_len;
                        r_bad_parity <= tx.cmd_bad_parity;
                        r_header     <= w_cmd_header;
                        r_parity     <= w_cmd_header;
                        r_wcnt       <= '0;
                        r_rcnt       <= '0;
                    end
                end
                TX_FILL: begin
                    if (w_wr_en) begin
                        r_wcnt   <= r_wcnt + 6'd1;
                        r_parity <= r_parity ^ tx.pl_data;
                    end
                end
                TX_PAYLOAD: begin
                    if (w_xfer) begin
                        r_rcnt <= r_rcnt + 6'd1;
                    end
                end
                TX_PARITY: begin
                    if (w_xfer) begin
                        r_gcnt <= '0;
                    end
                end
                TX_GAP: begin
                    r_gcnt <= r_gcnt + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign tx.cmd_ready = w_cmd_ready;
    assign tx.cmd_err   = r_cmd_err;
    assign tx.pl_ready  = (r_state == TX_FILL);
    assign tx.data_out  = w_data_out;
    assign tx.pkt_valid = w_pkt_valid;
    assign tx.done      = (r_state == TX_GAP) && w_gap_last;

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
`default_nettype none
// ============================================================================
// tb_router_pkt_tx : directed bench for router_pkt_tx
// Revision         : 1.0
// ============================================================================
module tb_router_pkt_tx;

    localparam int GAP = 2;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] pl [0:63];

    router_pkt_tx_if u_if ();

    router_pkt_tx #(
        .GAP_CYCLES (GAP)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .tx     (u_if.master)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic send_cmd(input logic [1:0] dest, input logic [5:0] len, input logic bad,
                            input string name);
        int w = 0;
        while (u_if.cmd_ready !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        chk({name, "_cmd_ready"}, {7'd0, u_if.cmd_ready}, 8'h01);
        u_if.cmd_valid      = 1'b1;
        u_if.cmd_dest       = dest;
        u_if.cmd_len        = len;
        u_if.cmd_bad_parity = bad;
        step();
        u_if.cmd_valid      = 1'b0;
        u_if.cmd_bad_parity = 1'b0;
    endtask

    task automatic do_fill(input int len, input string name);
        chk({name, "_pl_ready"}, {7'd0, u_if.pl_ready}, 8'h01);
        for (int i = 0; i < len; i++) begin
            u_if.pl_valid = 1'b1;
            u_if.pl_data  = pl[i];
            step();
        end
        u_if.pl_valid = 1'b0;
        u_if.pl_data  = 8'h00;
    endtask

    task automatic run_packet(input logic [1:0] dest, input int len, input logic bad,
                              input logic [7:0] exp_hdr, input logic [7:0] exp_par,
                              input int busy_at, input int busy_n, input string name);
        int e = 0;
        int c = 0;
        logic [7:0] exp_b;
        send_cmd(dest, 6'(len), bad, name);
        do_fill(len, name);
        chk({name, "_hdr_cmd_ready"}, {7'd0, u_if.cmd_ready}, 8'h00);
        chk({name, "_hdr_pl_ready"},  {7'd0, u_if.pl_ready},  8'h00);
        while (e < len + 2 && c < len + 6 + busy_n) begin
            exp_b = (e == 0) ? exp_hdr : ((e <= len) ? pl[e-1] : exp_par);
            chk($sformatf("%s_data_c%0d", name, c), u_if.data_out, exp_b);
            chk($sformatf("%s_pv_c%0d", name, c), {7'd0, u_if.pkt_valid}, {7'd0, (e <= len)});
            u_if.busy = (c >= busy_at) && (c < busy_at + busy_n);
            if (!u_if.busy) e++;
            c++;
            step();
        end
        u_if.busy = 1'b0;
        chk({name, "_wire_cycles"}, 8'(c), 8'(len + 2 + busy_n));
        for (int g = 0; g < GAP; g++) begin
            chk($sformatf("%s_gap_data_%0d", name, g), u_if.data_out, 8'h00);
            chk($sformatf("%s_gap_pv_%0d", name, g), {7'd0, u_if.pkt_valid}, 8'h00);
            chk($sformatf("%s_gap_done_%0d", name, g), {7'd0, u_if.done}, {7'd0, (g == GAP - 1)});
            step();
        end
        chk({name, "_post_done"},  {7'd0, u_if.done},      8'h00);
        chk({name, "_post_ready"}, {7'd0, u_if.cmd_ready}, 8'h01);
    endtask

    task automatic reject(input logic [1:0] dest, input logic [5:0] len, input string name);
        send_cmd(dest, len, 1'b0, name);
        u_if.pl_valid = 1'b1;
        chk({name, "_err"},       {7'd0, u_if.cmd_err},   8'h01);
        chk({name, "_pv"},        {7'd0, u_if.pkt_valid}, 8'h00);
        chk({name, "_pl_ready"},  {7'd0, u_if.pl_ready},  8'h00);
        chk({name, "_cmd_ready"}, {7'd0, u_if.cmd_ready}, 8'h01);
        step();
        u_if.pl_valid = 1'b0;
        chk({name, "_err_clr"},   {7'd0, u_if.cmd_err},   8'h00);
        chk({name, "_pv_after"},  {7'd0, u_if.pkt_valid}, 8'h00);
    endtask

    initial begin
        u_if.cmd_valid      = 1'b0;
        u_if.cmd_dest       = 2'd0;
        u_if.cmd_len        = 6'd0;
        u_if.cmd_bad_parity = 1'b0;
        u_if.pl_valid       = 1'b0;
        u_if.pl_data        = 8'h00;
        u_if.busy           = 1'b0;
        resetn              = 1'b0;
        repeat (3) @(negedge clock);

        chk("rst_data",      u_if.data_out,              8'h00);
        chk("rst_pv",        {7'd0, u_if.pkt_valid},     8'h00);
        chk("rst_cmd_ready", {7'd0, u_if.cmd_ready},     8'h00);
        chk("rst_pl_ready",  {7'd0, u_if.pl_ready},      8'h00);
        chk("rst_cmd_err",   {7'd0, u_if.cmd_err},       8'h00);
        chk("rst_done",      {7'd0, u_if.done},          8'h00);
        resetn = 1'b1;
        chk("rel_cmd_ready_lo", {7'd0, u_if.cmd_ready},  8'h00);
        step();
        chk("rel_cmd_ready_hi", {7'd0, u_if.cmd_ready},  8'h01);

        // dest=1 len=3: header 0x0D, parity 0x0D^A1^B2^C3 = 0xDD
        pl[0] = 8'hA1; pl[1] = 8'hB2; pl[2] = 8'hC3;
        run_packet(2'd1, 3, 1'b0, 8'h0D, 8'hDD, 0, 0, "basic");
        run_packet(2'd1, 3, 1'b0, 8'h0D, 8'hDD, 2, 3, "busy");

        reject(2'd3, 6'd2, "rej_dest");
        reject(2'd1, 6'd0, "rej_len");

        // dest=2 len=2: header 0x0A, parity 0x0A^5A^3C = 0x6C
        pl[0] = 8'h5A; pl[1] = 8'h3C;
        run_packet(2'd2, 2, 1'b0, 8'h0A, 8'h6C, 0, 0, "after_rej");

        // len=63: header 0xFC, XOR(0x00..0x3E)=0x3F, parity 0xC3
        for (int i = 0; i < 63; i++) pl[i] = 8'(i);
        run_packet(2'd0, 63, 1'b0, 8'hFC, 8'hC3, 0, 0, "max_len");

        // bad parity: header 0x04 ^ 0x55 = 0x51, inverted 0xAE
        pl[0] = 8'h55;
        run_packet(2'd0, 1, 1'b1, 8'h04, 8'hAE, 0, 0, "bad_par");

        // reset during PAYLOAD: dest=2 len=4 header 0x12
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
        send_cmd(2'd2, 6'd4, 1'b0, "mid_rst");
        do_fill(4, "mid_rst");
        chk("mid_rst_hdr", u_if.data_out, 8'h12);
        step();
        step();
        chk("mid_rst_pl1",    u_if.data_out,          8'h22);
        chk("mid_rst_pl1_pv", {7'd0, u_if.pkt_valid}, 8'h01);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_data_0", u_if.data_out,          8'h00);
        chk("mid_rst_pv_0",   {7'd0, u_if.pkt_valid}, 8'h00);
        chk("mid_rst_rdy_0",  {7'd0, u_if.cmd_ready}, 8'h00);
        @(negedge clock);
        resetn = 1'b1;
        step();

        pl[0] = 8'h5A; pl[1] = 8'h3C;
        run_packet(2'd2, 2, 1'b0, 8'h0A, 8'h6C, 0, 0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
